partial_pooling: RTL and testbench

Signed two-input max stage of the CNN max-pooling datapath. Each call compares two packed 22-bit two's-complement activations and returns the larger one. The result is available combinationally and also as a registered copy with valid and winner-select flags. An accumulate option folds the pair maximum into the previously registered result, so a 2x2 window resolves over two consecutive row pairs.

---
 rtl/partial_pooling.sv | 69 ++++++
 tb/tb_partial_pooling.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/partial_pooling.sv
// Signed two-input max stage for CNN max pooling: combinational pair max plus a
// registered result that can fold successive pair maxima into one window value.
module partial_pooling #(
   parameter int DATA_W = 22
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   input  logic                i_acc,
   input  logic [2*DATA_W-1:0] i_data,
   output logic [DATA_W-1:0]   o_data,
   output logic                o_sel,
   output logic [DATA_W-1:0]   o_data_r,
   output logic                o_sel_r,
   output logic                o_valid
);

   logic signed [DATA_W-1:0] data_0;
   logic signed [DATA_W-1:0] data_1;
   logic signed [DATA_W-1:0] pair_max;
   logic                     pair_sel;

   logic signed [DATA_W-1:0] data_q, data_d;
   logic                     sel_q, sel_d;
   logic                     valid_q;

   assign data_0 = $signed(i_data[DATA_W-1:0]);
   assign data_1 = $signed(i_data[2*DATA_W-1:DATA_W]);

   // Ties go to data_1, so only a strict win by data_0 clears the select.
   assign pair_sel = !(data_0 > data_1);
   assign pair_max = pair_sel ? data_1 : data_0;

   always_comb begin
      data_d = data_q;
      sel_d  = sel_q;
      if (i_valid) begin
         if (!i_acc) begin
            data_d = pair_max;
            sel_d  = pair_sel;
         end else if (pair_max > data_q) begin
            data_d = pair_max;
            sel_d  = 1'b1;
         end else begin
            // Stored value kept, including on a tie.
            sel_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         sel_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         sel_q   <= sel_d;
         valid_q <= i_valid;
      end
   end

   assign o_data   = pair_max;
   assign o_sel    = pair_sel;
   assign o_data_r = data_q;
   assign o_sel_r  = sel_q;
   assign o_valid  = valid_q;

endmodule

// File: tb/tb_partial_pooling.sv
// Self-checking bench for partial_pooling: directed vector table, accumulate and
// reset sequences, and a random sweep against an integer reference model.
module tb_partial_pooling;

   localparam int DATA_W = 22;

   logic                clk = 1'b0;
   logic                rst;
   logic                i_valid;
   logic                i_acc;
   logic [2*DATA_W-1:0] i_data;
   logic [DATA_W-1:0]   o_data;
   logic                o_sel;
   logic [DATA_W-1:0]   o_data_r;
   logic                o_sel_r;
   logic                o_valid;

   int checks   = 0;
   int failures = 0;

   // Reference model state, kept as plain signed integers.
   int m_data_r;
   int m_sel_r;
   int m_valid;

   partial_pooling #(.DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (i_valid),
      .i_acc    (i_acc),
      .i_data   (i_data),
      .o_data   (o_data),
      .o_sel    (o_sel),
      .o_data_r (o_data_r),
      .o_sel_r  (o_sel_r),
      .o_valid  (o_valid)
   );

   always #5 clk = ~clk;

   function automatic int to_int(input logic [DATA_W-1:0] v);
      int u;
      u = int'(v);
      return (u >= (1 << (DATA_W - 1))) ? u - (1 << DATA_W) : u;
   endfunction

   function automatic logic [DATA_W-1:0] to_word(input int v);
      logic [31:0] w;
      w = v;
      return w[DATA_W-1:0];
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One clock of stimulus: drive at negedge, check comb, then check registered
   // outputs just after the rising edge against the model.
   task automatic step(input logic r, input logic v, input logic a, input int d1, input int d0);
      int mx;
      int ms;
      @(negedge clk);
      rst     = r;
      i_valid = v;
      i_acc   = a;
      i_data  = {to_word(d1), to_word(d0)};
      #1;
      mx = (d0 > d1) ? d0 : d1;
      ms = (d0 > d1) ? 0 : 1;
      chk("comb_data", to_int(o_data), mx);
      chk("comb_sel", int'(o_sel), ms);
      @(posedge clk);
      if (r) begin
         m_data_r = 0; m_sel_r = 0; m_valid = 0;
      end else begin
         m_valid = int'(v);
         if (v) begin
            if (!a) begin
               m_data_r = mx; m_sel_r = ms;
            end else if (mx > m_data_r) begin
               m_data_r = mx; m_sel_r = 1;
            end else begin
               m_sel_r = 0;
            end
         end
      end
      #1;
      chk("reg_data", to_int(o_data_r), m_data_r);
      chk("reg_sel", int'(o_sel_r), m_sel_r);
      chk("reg_valid", int'(o_valid), m_valid);
   endtask

   typedef struct {
      logic [DATA_W-1:0] d0;
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] exp_data;
      logic              exp_sel;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{22'h1FFFFF, 22'h200000, 22'h1FFFFF, 1'b0};
      vecs[1] = '{22'h200000, 22'h1FFFFF, 22'h1FFFFF, 1'b1};
      vecs[2] = '{22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 1'b1};
      vecs[3] = '{22'h3FFFFB, 22'h3FFFFD, 22'h3FFFFD, 1'b1};
      vecs[4] = '{22'h200000, 22'h000000, 22'h000000, 1'b1};
      vecs[5] = '{22'h000010, 22'h00000F, 22'h000010, 1'b0};

      rst = 1'b1; i_valid = 1'b1; i_acc = 1'b0; i_data = '0;
      m_data_r = 0; m_sel_r = 0; m_valid = 0;

      // Reset with i_valid high must still clear everything.
      step(1'b1, 1'b1, 1'b0, 100, 50);
      chk("rst_data_r", int'(o_data_r), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_sel_r", int'(o_sel_r), 0);

      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         rst = 1'b0; i_valid = 1'b1; i_acc = 1'b0;
         i_data = {vecs[k].d1, vecs[k].d0};
         #1;
         chk($sformatf("vec%0d_data", k), int'(o_data), int'(vecs[k].exp_data));
         chk($sformatf("vec%0d_sel", k), int'(o_sel), int'(vecs[k].exp_sel));
         step(1'b0, 1'b1, 1'b0, to_int(vecs[k].d1), to_int(vecs[k].d0));
         chk($sformatf("vec%0d_data_r", k), int'(o_data_r), int'(vecs[k].exp_data));
      end

      // 2x2 accumulate window.
      step(1'b0, 1'b1, 1'b0, 7, -2);
      chk("acc1_data_r", to_int(o_data_r), 7);
      chk("acc1_sel_r", int'(o_sel_r), 1);
      step(1'b0, 1'b1, 1'b1, 3, 10);
      chk("acc2_data_r", to_int(o_data_r), 10);
      chk("acc2_sel_r", int'(o_sel_r), 1);
      chk("acc2_valid", int'(o_valid), 1);
      step(1'b0, 1'b1, 1'b1, 1, 4);
      chk("acc3_data_r", to_int(o_data_r), 10);
      chk("acc3_sel_r", int'(o_sel_r), 0);

      // Hold with i_valid low; i_acc toggled to show it is ignored.
      step(1'b0, 1'b1, 1'b0, 5, 1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, k[0], 1000, 2000);
         chk($sformatf("hold%0d_data_r", k), to_int(o_data_r), 5);
         chk($sformatf("hold%0d_valid", k), int'(o_valid), 0);
      end

      // Reset mid-window, then accumulate against the cleared zero.
      step(1'b0, 1'b1, 1'b0, 9, 2);
      chk("mid_load", to_int(o_data_r), 9);
      step(1'b1, 1'b0, 1'b0, 0, 0);
      chk("mid_rst", to_int(o_data_r), 0);
      step(1'b0, 1'b1, 1'b1, -4, -6);
      chk("mid_acc_data_r", to_int(o_data_r), 0);
      chk("mid_acc_sel_r", int'(o_sel_r), 0);
      chk("mid_acc_valid", int'(o_valid), 1);

      // Random sweep.
      for (int k = 0; k < 1000; k++) begin
         logic [DATA_W-1:0] r0, r1;
         logic rv, ra, rr;
         r0 = $urandom();
         r1 = $urandom();
         if (k % 5 == 0) r1 = r0;
         rv = ($urandom_range(0, 3) != 0);
         ra = $urandom_range(0, 1);
         rr = ($urandom_range(0, 49) == 0);
         step(rr, rv, ra, to_int(r1), to_int(r0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
